// File: rtl/svc_rv_mem_model_pkg.sv
// rtl/svc_rv_mem_model_pkg.sv - shared constants and byte-strobe merge for svc_rv_mem_model
package svc_rv_mem_model_pkg;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int MAX_RD_LATENCY = 4;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/svc_rv_mem_rd_pipe.sv
// rtl/svc_rv_mem_rd_pipe.sv - {valid, data} delay line of depth LATENCY with held output
module svc_rv_mem_rd_pipe #(
  parameter int          LATENCY = 1,
  parameter logic [31:0] INIT    = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  if (LATENCY == 0) begin : g_comb
    logic [31:0] hold_q;
    logic [31:0] hold_d;

    always_comb begin
      hold_d = hold_q;
      if (in_valid) hold_d = in_data;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) hold_q <= INIT;
      else       hold_q <= hold_d;
    end

    assign out_valid = in_valid;
    assign out_data  = in_valid ? in_data : hold_q;
  end else begin : g_pipe
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];

    always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      // The last stage doubles as the hold register: it only loads on delivery.
      if (!valid_d[LATENCY-1]) data_d[LATENCY-1] = data_q[LATENCY-1];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q <= '0;
        for (int i = 0; i < LATENCY; i++) data_q[i] <= INIT;
      end else begin
        valid_q <= valid_d;
        for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
      end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
  end

endmodule

// File: rtl/svc_rv_mem_model.sv
// rtl/svc_rv_mem_model.sv - shared imem/dmem word array with 0..4 cycle read latency
// Define SVC_RV_MEM_MODEL_WFWD_EN for write-first same-cycle read forwarding.
module svc_rv_mem_model
  import svc_rv_mem_model_pkg::*;
#(
  parameter int          WORDS      = 32,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] IMEM_INIT  = NOP,
  parameter logic [31:0] DMEM_INIT  = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_arvalid,
  input  logic [31:0] imem_araddr,
  output logic [31:0] imem_rdata,
  output logic        imem_rvalid,
  input  logic        dmem_ren,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rvalid,
  input  logic        dmem_we,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb
);

  localparam int AW = $clog2(WORDS);

  if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0) ||
      (RD_LATENCY < 0) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_bad_cfg
    $error("svc_rv_mem_model: WORDS must be a power of two >= 2 and RD_LATENCY 0..4");
  end

  logic [AW-1:0] iidx;
  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;

  assign iidx = imem_araddr[AW+1:2];
  assign ridx = dmem_raddr[AW+1:2];
  assign widx = dmem_waddr[AW+1:2];

  // Byte offsets and aliased upper bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_araddr[31:AW+2], imem_araddr[1:0],
                              dmem_raddr[31:AW+2], dmem_raddr[1:0],
                              dmem_waddr[31:AW+2], dmem_waddr[1:0]};

  logic [31:0] mem_q [WORDS];
  logic        wr_en;
  logic [31:0] wr_word_d;
  logic [31:0] imem_word;
  logic [31:0] dmem_word;
  logic        imem_req;
  logic        dmem_req;

  always_comb begin
    wr_en     = dmem_we & ~reset;
    wr_word_d = merge_wstrb(mem_q[widx], dmem_wdata, dmem_wstrb);
    imem_req  = imem_arvalid & ~reset;
    dmem_req  = dmem_ren & ~reset;
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[widx] <= wr_word_d;
  end

  always_comb begin
    imem_word = mem_q[iidx];
    dmem_word = mem_q[ridx];
`ifdef SVC_RV_MEM_MODEL_WFWD_EN
    if (dmem_we && (widx == iidx)) imem_word = wr_word_d;
    if (dmem_we && (widx == ridx)) dmem_word = wr_word_d;
`endif
  end

  svc_rv_mem_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .INIT    (IMEM_INIT)
  ) u_imem_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (imem_req),
    .in_data   (imem_word),
    .out_valid (imem_rvalid),
    .out_data  (imem_rdata)
  );

  svc_rv_mem_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .INIT    (DMEM_INIT)
  ) u_dmem_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (dmem_req),
    .in_data   (dmem_word),
    .out_valid (dmem_rvalid),
    .out_data  (dmem_rdata)
  );

endmodule
